// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: parallel/serial data, mode
// control, burst handshake and register outputs.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] D;
  logic [2:0]       MODE;
  logic             G_b;
  logic             SL;
  logic             SR;
  logic             START;
  logic [CW-1:0]    COUNT;
  logic [WIDTH-1:0] Q;
  logic             QA;
  logic             QH;
  logic             BUSY;
  logic             DONE;

  modport master (
    output D, MODE, G_b, SL, SR, START, COUNT,
    input  Q, QA, QH, BUSY, DONE
  );

  modport slave (
    input  D, MODE, G_b, SL, SR, START, COUNT,
    output Q, QA, QH, BUSY, DONE
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with hold/shift/rotate/arithmetic
// shift/load/clear modes and a burst engine that runs a programmed number of
// shifts on its own, reporting progress on BUSY and completion on DONE.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input logic             CK,
  input logic             CLR_b,
  univ_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [2:0]       lmode_q, lmode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_shift;
  logic             accept;
  logic             abort;
  logic             last_shift;
  logic [CW-1:0]    n_eff;

  // One step of any shift-class mode; non-shift codes return the value unchanged.
  function automatic logic [WIDTH-1:0] shift_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic             sl,
                                                input logic             sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_SHR:   r = {sr, v[WIDTH-1:1]};
      M_SHL:   r = {v[WIDTH-2:0], sl};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign is_shift   = (bus.MODE == M_SHR) || (bus.MODE == M_SHL) || (bus.MODE == M_ROR) ||
                      (bus.MODE == M_ROL) || (bus.MODE == M_ASR);
  assign accept     = (state_q == IDLE) && bus.START && is_shift && !bus.G_b;
  // Bursts longer than the register width are clamped to WIDTH shifts.
  assign n_eff      = (bus.COUNT > CW'(WIDTH)) ? CW'(WIDTH) : bus.COUNT;
  assign abort      = (state_q == BURST) && (bus.MODE == M_CLR);
  assign last_shift = (state_q == BURST) && !abort && !bus.G_b && (rem_q == CW'(1));

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CK or negedge CLR_b) begin
    if (!CLR_b) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      lmode_q <= M_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      lmode_q <= lmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: enter BURST only when an accepted request needs two or more shifts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (n_eff >= CW'(2))) state_d = BURST;
      BURST:   if (abort || last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake outputs: live MODE in IDLE, latched mode during a burst.
  always_comb begin
    q_d     = q_q;
    rem_d   = rem_q;
    lmode_d = lmode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      case (bus.MODE)
        M_HOLD:  q_d = q_q;
        M_LOAD:  q_d = bus.D;
        M_CLR:   q_d = '0;
        default: if (!bus.G_b) q_d = shift_op(bus.MODE, q_q, bus.SL, bus.SR);
      endcase
      if (accept) begin
        lmode_d = bus.MODE;
        if (n_eff == '0) begin
          // A zero-length burst completes without touching the register.
          q_d    = q_q;
          done_d = 1'b1;
        end else if (n_eff == CW'(1)) begin
          done_d = 1'b1;
        end else begin
          rem_d  = n_eff - CW'(1);
          busy_d = 1'b1;
        end
      end
    end else begin
      if (abort) begin
        q_d    = '0;
        rem_d  = '0;
        busy_d = 1'b0;
      end else if (!bus.G_b) begin
        q_d   = shift_op(lmode_q, q_q, bus.SL, bus.SR);
        rem_d = rem_q - CW'(1);
        if (rem_q == CW'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.QA   = q_q[WIDTH-1];
  assign bus.QH   = q_q[0];
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the next generation of our 8-bit TTL-style shift register models. Adds width generalisation, rotate and arithmetic-shift modes, synchronous clear, and a burst engine that performs a programmed number of shifts autonomously with BUSY/DONE handshake. Used wherever the design needs multi-bit serialisation or scaling, e.g. sound-channel frequency sweep and serial link shifting.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
CW (localparam), $clog2(WIDTH+1), width of COUNT.

Ports:
CK  input  1  clock; all state changes on rising edge
CLR_b  input  1  asynchronous active-low reset
D  input  WIDTH  parallel load data
MODE  input  3  operation select (see Behaviour)
G_b  input  1  active-low shift enable; does not gate load or reset
SL  input  1  serial input entering Q[0] on shift left
SR  input  1  serial input entering Q[WIDTH-1] on shift right
START  input  1  burst request, sampled on rising edge
COUNT  input  CW  burst length in shifts
Q  output  WIDTH  register contents
QA  output  1  combinational copy of Q[WIDTH-1]
QH  output  1  combinational copy of Q[0]
BUSY  output  1  burst in progress
DONE  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset (CLR_b low, async, no clock needed): Q=0, state IDLE, remaining count=0, BUSY=0, DONE=0. Reset dominates every other input. Deassertion is synchronised externally.
- MODE encoding, applied per edge: 000 hold; 001 shift right {SR,Q[W-1:1]}; 010 shift left {Q[W-2:0],SL}; 011 parallel load D; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 synchronous clear to 0.
- G_b high: modes 001,010,100,101,110 hold. Modes 011 and 111 execute regardless of G_b.
- Shift class = {001,010,100,101,110}.
- Registered outputs: Q, BUSY, DONE. QA and QH track Q combinationally with zero-cycle skew.
- FSM states: IDLE, BURST.
- IDLE: MODE executes each edge. START is accepted when MODE is in the shift class and G_b is low.
  - On acceptance edge k:
    - Latch MODE.
    - Perform the first shift at edge k.
    - Set effective count n = min(COUNT, WIDTH).
  - n==1: stay IDLE, DONE=1 after edge k.
  - n>=2: go to BURST, remaining=n-1, BUSY=1.
  - COUNT==0 with an otherwise valid START: no shift, DONE=1 after edge k, state stays IDLE.
  - START with a non-shift MODE, or with G_b high: ignored, no DONE, MODE executes normally.
- BURST:
  - MODE and START are ignored, except MODE=111, which aborts: Q=0, IDLE, BUSY=0, DONE not asserted.
  - Each edge with G_b low: apply the latched mode and decrement remaining. SL/SR are sampled live every shift.
  - G_b high: pause; Q and remaining are frozen and BUSY stays 1.
  - Edge with remaining==1 and G_b low: final shift, go to IDLE, BUSY=0, DONE=1.
- DONE is high for exactly one cycle, then cleared on the next edge. A new START may be accepted on the same edge DONE clears, and re-raises DONE appropriately.
- Unpaused latency: the burst occupies n consecutive edges starting at the START edge. BUSY is high for n-1 cycles.

Test Plan:
- Async reset (WIDTH=8): Q=8'h5A, drop CLR_b between edges -> Q=00, QA=QH=0, BUSY=DONE=0 immediately. Hold MODE=011 with CLR_b low -> Q stays 00.
- Load and gate: D=8'hA5, MODE=011, G_b=1 -> Q=A5, QA=1, QH=1. Then MODE=001, G_b=1 -> Q stays A5.
- Rotate burst: Q=A5, MODE=100, COUNT=3, START one cycle -> Q=D2,69,B4 on successive edges. BUSY high 2 cycles, DONE high 1 cycle after the third edge, final Q=B4.
- Arithmetic shift and pause: Q=90, MODE=110, COUNT=4, G_b high for 2 mid-burst cycles -> Q=F9 after 6 edges, BUSY high 5 cycles, one DONE pulse.
- Abort and clamp:
  - Burst MODE=010, SL=1, COUNT=4 from 00, MODE=111 on the 2nd edge -> Q=00, BUSY=0, no DONE.
  - MODE=001, SR=1, COUNT=12 from 00 -> Q=FF after 8 edges, DONE once.
- Degenerate START:
  - COUNT=0, MODE=001 -> Q unchanged, DONE pulse next cycle, BUSY never high.
  - START with MODE=011 -> load occurs, no DONE.
  - START during BURST -> ignored, no extra DONE.
